// File: rtl/vga_ctrl_pkg.sv
// Shared constants and control-state encoding for the blue-square VGA core.
package vga_ctrl_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int SQ_SIZE_DEF  = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/vga_square_motion_ctrl_axis_bounce.sv
// Single-axis position/direction register that bounces between 0 and LIMIT.
module axis_bounce #(
    parameter int POS_W = 10,
    parameter int LIMIT = 576
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             upd,
    input  logic [2:0]       speed,
    output logic [POS_W-1:0] pos,
    output logic             hit
);

    localparam logic [POS_W:0]   LIMIT_W   = LIMIT[POS_W:0];
    localparam logic [POS_W-1:0] RESET_POS = POS_W'(LIMIT / 2);

    logic             dir_neg;
    logic             dir_next;
    logic [POS_W-1:0] pos_next;
    logic [POS_W:0]   pos_w;
    logic [POS_W:0]   speed_w;
    logic [POS_W:0]   sum;

    // One extra bit on the sum so the upper-edge compare can never wrap.
    assign pos_w   = {1'b0, pos};
    assign speed_w = {{(POS_W-2){1'b0}}, speed};
    assign sum     = pos_w + speed_w;

    // hit reports what the pending update would do; the caller gates it with upd.
    always_comb begin
        pos_next = pos;
        dir_next = dir_neg;
        hit      = 1'b0;
        if (speed != 3'd0) begin
            if (!dir_neg) begin
                if (sum >= LIMIT_W) begin
                    pos_next = LIMIT_W[POS_W-1:0];
                    dir_next = 1'b1;
                    hit      = 1'b1;
                end else begin
                    pos_next = sum[POS_W-1:0];
                end
            end else begin
                if (pos_w <= speed_w) begin
                    pos_next = '0;
                    dir_next = 1'b0;
                    hit      = 1'b1;
                end else begin
                    pos_next = pos - speed_w[POS_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos     <= RESET_POS;
            dir_neg <= 1'b0;
        end else if (upd) begin
            pos     <= pos_next;
            dir_neg <= dir_next;
        end
    end

endmodule

// File: rtl/vga_square_motion_ctrl.sv
// Per-frame motion sequencer: moves and bounces the square once per frame tick,
// with a run/pause/single-step controller.
module vga_square_motion_ctrl
    import vga_ctrl_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int SQ_SIZE  = SQ_SIZE_DEF,
    parameter int POS_W    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             frame_tick,
    input  logic             run,
    input  logic             step,
    input  logic [2:0]       speed,
    output logic [POS_W-1:0] sq_x,
    output logic [POS_W-1:0] sq_y,
    output logic [1:0]       colour,
    output logic             bounce,
    output logic [7:0]       frame_cnt
);

    localparam int XMAX = H_ACTIVE - SQ_SIZE;
    localparam int YMAX = V_ACTIVE - SQ_SIZE;

    ctrl_state_t state;
    logic        step_pend;
    logic        upd;
    logic        hit_x;
    logic        hit_y;
    logic        any_hit;

    // Decision uses the pre-edge state, so a run change on a tick cycle takes effect next frame.
    assign upd     = ena && frame_tick &&
                     ((state == RUN) || ((state == PAUSED) && (step_pend || step)));
    assign any_hit = hit_x || hit_y;

    axis_bounce #(.POS_W(POS_W), .LIMIT(XMAX)) u_axis_x (
        .clk   (clk),
        .rst_n (rst_n),
        .upd   (upd),
        .speed (speed),
        .pos   (sq_x),
        .hit   (hit_x)
    );

    axis_bounce #(.POS_W(POS_W), .LIMIT(YMAX)) u_axis_y (
        .clk   (clk),
        .rst_n (rst_n),
        .upd   (upd),
        .speed (speed),
        .pos   (sq_y),
        .hit   (hit_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            step_pend <= 1'b0;
            colour    <= 2'd0;
            bounce    <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            bounce <= upd && any_hit;
            if (upd) begin
                frame_cnt <= frame_cnt + 8'd1;
                if (any_hit) begin
                    colour <= colour + 2'd1;
                end
            end
            if (ena) begin
                case (state)
                    IDLE: begin
                        if (run) begin
                            state <= RUN;
                        end
                    end
                    RUN: begin
                        if (!run) begin
                            state <= PAUSED;
                        end
                    end
                    PAUSED: begin
                        if (run) begin
                            state     <= RUN;
                            step_pend <= 1'b0;
                        end else if (upd) begin
                            step_pend <= 1'b0;
                        end else if (step) begin
                            step_pend <= 1'b1;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        step_pend <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vga_square_motion_ctrl.sv
// Directed bench for vga_square_motion_ctrl: a 640x480 instance plus a square
// 480x480 instance that hits both edges on the same update.
module tb_vga_square_motion_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       frame_tick;
    logic       run;
    logic       step;
    logic [2:0] speed;

    logic [9:0] a_x, a_y, b_x, b_y;
    logic [1:0] a_colour, b_colour;
    logic       a_bounce, b_bounce;
    logic [7:0] a_cnt, b_cnt;

    int num_checks = 0;
    int num_fails  = 0;

    typedef struct {
        logic       run;
        logic       step;
        logic       tick;
        logic       ena;
        logic [2:0] speed;
        int         x;
        int         y;
        int         colour;
        int         bounce;
        int         cnt;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    vga_square_motion_ctrl dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .frame_tick (frame_tick),
        .run        (run),
        .step       (step),
        .speed      (speed),
        .sq_x       (a_x),
        .sq_y       (a_y),
        .colour     (a_colour),
        .bounce     (a_bounce),
        .frame_cnt  (a_cnt)
    );

    vga_square_motion_ctrl #(.H_ACTIVE(480), .V_ACTIVE(480)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .frame_tick (frame_tick),
        .run        (run),
        .step       (step),
        .speed      (speed),
        .sq_x       (b_x),
        .sq_y       (b_y),
        .colour     (b_colour),
        .bounce     (b_bounce),
        .frame_cnt  (b_cnt)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    task automatic checkA(input string tag, input int x, input int y, input int c, input int b, input int n);
        checkOutput({tag, ".a_x"},      {22'd0, a_x},      x);
        checkOutput({tag, ".a_y"},      {22'd0, a_y},      y);
        checkOutput({tag, ".a_colour"}, {30'd0, a_colour}, c);
        checkOutput({tag, ".a_bounce"}, {31'd0, a_bounce}, b);
        checkOutput({tag, ".a_cnt"},    {24'd0, a_cnt},    n);
    endtask

    task automatic checkB(input string tag, input int x, input int y, input int c, input int b);
        checkOutput({tag, ".b_x"},      {22'd0, b_x},      x);
        checkOutput({tag, ".b_y"},      {22'd0, b_y},      y);
        checkOutput({tag, ".b_colour"}, {30'd0, b_colour}, c);
        checkOutput({tag, ".b_bounce"}, {31'd0, b_bounce}, b);
    endtask

    // Drive one cycle of inputs, let the edge sample them, then drop the pulses.
    task automatic applyStimulus(input logic r, input logic s, input logic t, input logic e, input logic [2:0] sp);
        run        = r;
        step       = s;
        frame_tick = t;
        ena        = e;
        speed      = sp;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        step       = 1'b0;
    endtask

    function automatic vec_t mkVec(bit r, bit s, bit t, bit e, int sp, int x, int y, int c, int b, int n);
        vec_t v;
        v.run    = r;
        v.step   = s;
        v.tick   = t;
        v.ena    = e;
        v.speed  = sp[2:0];
        v.x      = x;
        v.y      = y;
        v.colour = c;
        v.bounce = b;
        v.cnt    = n;
        return v;
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int a_hits;
        int b_hits;

        // Run/pause/step walk-through on the 640x480 instance; the 480x480
        // instance starts at 208/208 and tracks the same y value throughout.
        vecs.push_back(mkVec(0, 1, 1, 1, 4, 288, 208, 0, 0, 0));
        vecs.push_back(mkVec(1, 0, 0, 1, 4, 288, 208, 0, 0, 0));
        vecs.push_back(mkVec(1, 0, 1, 1, 4, 292, 212, 0, 0, 1));
        vecs.push_back(mkVec(1, 0, 0, 1, 4, 292, 212, 0, 0, 1));
        vecs.push_back(mkVec(1, 0, 1, 1, 4, 296, 216, 0, 0, 2));
        vecs.push_back(mkVec(1, 0, 1, 0, 4, 296, 216, 0, 0, 2));
        vecs.push_back(mkVec(1, 0, 1, 0, 4, 296, 216, 0, 0, 2));
        vecs.push_back(mkVec(1, 0, 1, 0, 4, 296, 216, 0, 0, 2));
        vecs.push_back(mkVec(1, 0, 1, 1, 4, 300, 220, 0, 0, 3));
        vecs.push_back(mkVec(0, 0, 0, 1, 4, 300, 220, 0, 0, 3));
        for (int i = 0; i < 5; i++) begin
            vecs.push_back(mkVec(0, 0, 1, 1, 4, 300, 220, 0, 0, 3));
        end
        vecs.push_back(mkVec(0, 1, 0, 1, 4, 300, 220, 0, 0, 3));
        vecs.push_back(mkVec(0, 0, 1, 1, 4, 304, 224, 0, 0, 4));
        vecs.push_back(mkVec(0, 0, 1, 1, 4, 304, 224, 0, 0, 4));
        vecs.push_back(mkVec(0, 1, 1, 1, 4, 308, 228, 0, 0, 5));
        vecs.push_back(mkVec(0, 0, 1, 1, 4, 308, 228, 0, 0, 5));
        vecs.push_back(mkVec(0, 1, 0, 1, 4, 308, 228, 0, 0, 5));
        vecs.push_back(mkVec(0, 1, 0, 1, 4, 308, 228, 0, 0, 5));
        vecs.push_back(mkVec(0, 0, 1, 1, 4, 312, 232, 0, 0, 6));
        vecs.push_back(mkVec(0, 0, 1, 1, 4, 312, 232, 0, 0, 6));
        vecs.push_back(mkVec(1, 0, 1, 1, 4, 312, 232, 0, 0, 6));
        vecs.push_back(mkVec(1, 0, 1, 1, 4, 316, 236, 0, 0, 7));
        vecs.push_back(mkVec(1, 1, 0, 1, 4, 316, 236, 0, 0, 7));
        vecs.push_back(mkVec(0, 0, 0, 1, 4, 316, 236, 0, 0, 7));
        vecs.push_back(mkVec(0, 0, 1, 1, 4, 316, 236, 0, 0, 7));

        rst_n      = 1'b0;
        ena        = 1'b1;
        run        = 1'b0;
        step       = 1'b0;
        frame_tick = 1'b0;
        speed      = 3'd4;
        repeat (2) @(posedge clk);
        #3;
        checkA("reset", 288, 208, 0, 0, 0);
        checkB("reset", 208, 208, 0, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].run, vecs[i].step, vecs[i].tick, vecs[i].ena, vecs[i].speed);
            checkA($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].colour, vecs[i].bounce, vecs[i].cnt);
            checkB($sformatf("vec%0d", i), vecs[i].y, vecs[i].y, 0, 0);
        end

        // Resume and run to x=400, then pulse reset between clock edges.
        applyStimulus(1, 0, 0, 1, 4);
        for (int k = 0; k < 21; k++) applyStimulus(1, 0, 1, 1, 4);
        checkA("pre_rst", 400, 320, 0, 0, 28);
        checkB("pre_rst", 320, 320, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkA("async_rst", 288, 208, 0, 0, 0);
        checkB("async_rst", 208, 208, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // IDLE ignores tick and step; entering RUN on a tick cycle does not update yet.
        applyStimulus(0, 1, 1, 1, 4);
        checkA("idle_tick", 288, 208, 0, 0, 0);
        applyStimulus(1, 0, 1, 1, 4);
        checkA("idle_to_run", 288, 208, 0, 0, 0);

        // Lower-edge approach on Y; simultaneous X/Y hit on the square instance.
        a_hits = 0;
        b_hits = 0;
        for (int k = 1; k <= 52; k++) begin
            applyStimulus(1, 0, 1, 1, 4);
            a_hits += int'(a_bounce);
            b_hits += int'(b_bounce);
            if (k == 51) checkA("tick51", 492, 412, 0, 0, 51);
            if (k == 52) begin
                checkA("tick52", 496, 416, 1, 1, 52);
                checkB("tick52", 416, 416, 1, 1);
            end
        end
        checkOutput("a_bounce_pulses", a_hits, 1);
        checkOutput("b_bounce_pulses", b_hits, 1);
        applyStimulus(1, 0, 0, 1, 4);
        checkA("after52", 496, 416, 1, 0, 52);
        checkB("after52", 416, 416, 1, 0);
        applyStimulus(1, 0, 1, 1, 4);
        checkA("tick53", 500, 412, 1, 0, 53);
        checkB("tick53", 412, 412, 1, 0);

        // Right edge, then speed 7 back to the left edge with a Y bounce on the way.
        for (int k = 1; k <= 19; k++) applyStimulus(1, 0, 1, 1, 4);
        checkA("x_right", 576, 336, 2, 1, 72);
        checkB("x_right", 336, 336, 1, 0);
        applyStimulus(1, 0, 1, 1, 2);
        checkA("speed2", 574, 334, 2, 0, 73);
        for (int k = 1; k <= 82; k++) begin
            applyStimulus(1, 0, 1, 1, 7);
            if (k == 48) checkA("y_top", 238, 0, 3, 1, 121);
            if (k == 81) checkA("x_at7", 7, 231, 3, 0, 154);
            if (k == 82) begin
                checkA("x_left", 0, 238, 0, 1, 155);
                checkB("speed7_end", 238, 238, 2, 0);
            end
        end

        // Speed 0 at the edge: updates still count but nothing moves or bounces.
        a_hits = 0;
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1, 0, 1, 1, 0);
            a_hits += int'(a_bounce);
        end
        checkOutput("speed0_bounces", a_hits, 0);
        checkA("speed0", 0, 238, 0, 0, 165);

        for (int k = 1; k <= 91; k++) begin
            applyStimulus(1, 0, 1, 1, 0);
            if (k == 90) checkOutput("cnt_255", {24'd0, a_cnt}, 255);
            if (k == 91) checkOutput("cnt_wrap", {24'd0, a_cnt}, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
